// File: rtl/pic_8259a_pkg.sv
// rtl/pic_8259a_pkg.sv - shared types and priority helper for the 8259A acknowledge path
package pic_8259a_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACK1,
        ACK2
    } state_t;

    localparam int IRQ_LEVELS = 8;

    // Fixed priority: IR0 wins. Returns 0 for an all-zero input; callers gate on |bits.
    function automatic logic [2:0] lowest_set_index(input logic [IRQ_LEVELS-1:0] bits);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = IRQ_LEVELS - 1; i >= 0; i--) begin
            if (bits[i]) begin
                idx = i[2:0];
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/pic_8259a_priority_resolver.sv
// rtl/pic_8259a_priority_resolver.sv - fixed-priority pick of the eligible request
module pic_8259a_priority_resolver
    import pic_8259a_pkg::*;
(
    input  logic [IRQ_LEVELS-1:0] irr,
    input  logic [IRQ_LEVELS-1:0] mask,
    input  logic [IRQ_LEVELS-1:0] isr,
    output logic                  eligible_any,
    output logic [2:0]            winner_level
);

    logic [IRQ_LEVELS-1:0] priority_limit;
    logic [IRQ_LEVELS-1:0] eligible;

    // Only levels strictly above the highest-priority in-service level may interrupt.
    always_comb begin
        priority_limit = '1;
        if (|isr) begin
            priority_limit = (8'h01 << lowest_set_index(isr)) - 8'h01;
        end
        eligible = irr & ~mask & priority_limit;
    end

    assign eligible_any = |eligible;
    assign winner_level = lowest_set_index(eligible);

endmodule

// File: rtl/pic_8259a_ack_sequencer.sv
// rtl/pic_8259a_ack_sequencer.sv - INT/INTA sequencer, in-service register and EOI handling
module pic_8259a_ack_sequencer
    import pic_8259a_pkg::*;
#(
    parameter logic [2:0] SPURIOUS_LEVEL = 3'd7
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [IRQ_LEVELS-1:0] interrupt_request_register,
    input  logic [IRQ_LEVELS-1:0] interrupt_mask,
    input  logic                  auto_eoi_config,
    input  logic [4:0]            vector_base,
    input  logic                  interrupt_acknowledge_n,
    input  logic                  end_of_interrupt,
    input  logic                  specific_eoi,
    input  logic [2:0]            specific_eoi_level,
    output logic                  interrupt_to_cpu,
    output logic                  freeze,
    output logic [IRQ_LEVELS-1:0] clear_interrupt_request,
    output logic [IRQ_LEVELS-1:0] in_service_register,
    output logic [7:0]            vector_out,
    output logic                  vector_out_enable,
    output logic                  spurious
);

    state_t                state;
    logic                  prev_inta;
    logic [2:0]            level;
    logic                  eligible_any;
    logic [2:0]            winner_level;
    logic                  inta_fall;
    logic                  inta_rise;
    logic [IRQ_LEVELS-1:0] eoi_clear;
    logic [IRQ_LEVELS-1:0] auto_clear;
    logic [IRQ_LEVELS-1:0] grant_set;
    logic [IRQ_LEVELS-1:0] isr_next;

    pic_8259a_priority_resolver u_resolver (
        .irr          (interrupt_request_register),
        .mask         (interrupt_mask),
        .isr          (in_service_register),
        .eligible_any (eligible_any),
        .winner_level (winner_level)
    );

    assign inta_fall = prev_inta & ~interrupt_acknowledge_n;
    assign inta_rise = ~prev_inta & interrupt_acknowledge_n;

    // Clears come from the pre-update ISR; a grant in the same cycle overrides any clear.
    always_comb begin
        eoi_clear  = '0;
        auto_clear = '0;
        grant_set  = '0;
        if (end_of_interrupt && |in_service_register) begin
            eoi_clear[lowest_set_index(in_service_register)] = 1'b1;
        end
        if (specific_eoi) begin
            eoi_clear[specific_eoi_level] = 1'b1;
        end
        if (state == ACK2 && inta_rise && auto_eoi_config && !spurious) begin
            auto_clear[level] = 1'b1;
        end
        if (state == IDLE && inta_fall && eligible_any) begin
            grant_set[winner_level] = 1'b1;
        end
        isr_next = (in_service_register & ~eoi_clear & ~auto_clear) | grant_set;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state                   <= IDLE;
            prev_inta               <= 1'b1;
            level                   <= 3'd0;
            interrupt_to_cpu        <= 1'b0;
            freeze                  <= 1'b0;
            clear_interrupt_request <= '0;
            in_service_register     <= '0;
            vector_out              <= 8'h00;
            vector_out_enable       <= 1'b0;
            spurious                <= 1'b0;
        end else begin
            prev_inta               <= interrupt_acknowledge_n;
            clear_interrupt_request <= '0;
            in_service_register     <= isr_next;
            case (state)
                IDLE: begin
                    interrupt_to_cpu <= eligible_any;
                    if (inta_fall) begin
                        state            <= ACK1;
                        freeze           <= 1'b1;
                        interrupt_to_cpu <= 1'b0;
                        if (eligible_any) begin
                            level                   <= winner_level;
                            clear_interrupt_request <= 8'h01 << winner_level;
                            spurious                <= 1'b0;
                        end else begin
                            level    <= SPURIOUS_LEVEL;
                            spurious <= 1'b1;
                        end
                    end
                end
                ACK1: begin
                    interrupt_to_cpu <= 1'b0;
                    if (inta_fall) begin
                        state             <= ACK2;
                        vector_out        <= {vector_base, level};
                        vector_out_enable <= 1'b1;
                    end
                end
                ACK2: begin
                    interrupt_to_cpu <= 1'b0;
                    if (inta_rise) begin
                        state             <= IDLE;
                        freeze            <= 1'b0;
                        vector_out_enable <= 1'b0;
                        spurious          <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
